stream_in_vector_ping_pong: RTL and testbench

Serial-to-vector collector that sits directly upstream of the vector serializer. It accepts one BITS-wide element per cycle and assembles N elements into a vector. Two banks (ping/pong) let the next vector fill while the previous one is held for the consumer. Valid/ready handshake on both sides, plus early frame termination and an overflow flag.

---
 rtl/stream_vec_pkg.sv | 14 +
 rtl/vector_bank.sv | 67 ++++++
 rtl/stream_in_vector_ping_pong.sv | 88 ++++++++
 tb/tb_stream_in_vector_ping_pong.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/stream_vec_pkg.sv
// Shared types and width helpers for the ping-pong vector collector.
package stream_vec_pkg;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;

  // Width of an element index counter; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_N     = 3;
  localparam int DEF_CNT_W = cnt_w(DEF_N);

endpackage

// File: rtl/vector_bank.sv
// One storage bank: N elements, fill state and latched length.
// state   | meaning
// EMPTY   | no data; storage reads as zero
// FILLING | at least one element written, vector not complete
// FULL    | vector complete, held for the consumer
module vector_bank
  import stream_vec_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int N     = 3,
  parameter int CNT_W = cnt_w(N),
  parameter int LEN_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             wr_done,
  input  logic [CNT_W-1:0] wr_idx,
  input  logic [BITS-1:0]  wr_data,
  input  logic             rd_ack,
  output bank_state_t      state,
  output logic [BITS-1:0]  data [N],
  output logic [LEN_W-1:0] len
);

  bank_state_t      state_q, state_d;
  logic [BITS-1:0]  mem_q [N];
  logic [BITS-1:0]  mem_d [N];
  logic [LEN_W-1:0] len_q, len_d;

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    len_d   = len_q;
    if (wr_en) begin
      mem_d[wr_idx] = wr_data;
      state_d       = FILLING;
      if (wr_done) begin
        state_d = FULL;
        len_d   = LEN_W'(wr_idx) + LEN_W'(1);
      end
    end
    // Clearing on release keeps unwritten slots of a short vector at zero.
    if (rd_ack) begin
      state_d = EMPTY;
      len_d   = '0;
      for (int i = 0; i < N; i++) mem_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      len_q   <= '0;
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      for (int i = 0; i < N; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign state = state_q;
  assign data  = mem_q;
  assign len   = len_q;

endmodule

// File: rtl/stream_in_vector_ping_pong.sv
// Serial-to-vector collector with two ping-pong banks and valid/ready on both sides.
module stream_in_vector_ping_pong
  import stream_vec_pkg::*;
#(
  parameter int BITS = 8,
  parameter int N    = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [BITS-1:0]          b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BITS-1:0]          a [N],
  output logic [$clog2(N+1)-1:0]   out_len,
  output logic                     overflow
);

  localparam int CNT_W = cnt_w(N);
  localparam int LEN_W = $clog2(N + 1);

  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  bank_state_t      bank_state [2];
  logic [BITS-1:0]  bank_data  [2][N];
  logic [LEN_W-1:0] bank_len   [2];

  logic accept, done, rd_ack;

  assign in_ready  = (bank_state[wr_bank_q] != FULL);
  assign out_valid = (bank_state[rd_bank_q] == FULL);
  assign accept    = in_valid && in_ready;
  assign done      = accept && (in_last || (count_q == CNT_W'(N - 1)));
  assign rd_ack    = out_valid && out_ready;

  always_comb begin
    count_d    = count_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    overflow_d = overflow_q || (in_valid && !in_ready);
    if (done) begin
      count_d   = '0;
      wr_bank_d = !wr_bank_q;
    end else if (accept) begin
      count_d = count_q + CNT_W'(1);
    end
    if (rd_ack) rd_bank_d = !rd_bank_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      overflow_q <= overflow_d;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    vector_bank #(.BITS(BITS), .N(N), .CNT_W(CNT_W), .LEN_W(LEN_W)) u_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (accept && (wr_bank_q == 1'(g))),
      .wr_done (done && (wr_bank_q == 1'(g))),
      .wr_idx  (count_q),
      .wr_data (b),
      .rd_ack  (rd_ack && (rd_bank_q == 1'(g))),
      .state   (bank_state[g]),
      .data    (bank_data[g]),
      .len     (bank_len[g])
    );
  end

  assign a        = bank_data[rd_bank_q];
  assign out_len  = bank_len[rd_bank_q];
  assign overflow = overflow_q;

endmodule

// File: tb/tb_stream_in_vector_ping_pong.sv
// Directed self-checking bench for stream_in_vector_ping_pong (BITS=8, N=3).
module tb_stream_in_vector_ping_pong;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_last, out_ready;
  logic [7:0] b;
  logic       in_ready, out_valid, overflow;
  logic [7:0] a [3];
  logic [1:0] out_len;

  int checks = 0;
  int errors = 0;

  stream_in_vector_ping_pong #(.BITS(8), .N(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .out_len   (out_len),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic last, input logic [7:0] d, input logic ordy);
    in_valid  = v;
    in_last   = last;
    b         = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [1:0] elen);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".a0"}, 32'(a[0]), 32'(e0));
    chk({tag, ".a1"}, 32'(a[1]), 32'(e1));
    chk({tag, ".a2"}, 32'(a[2]), 32'(e2));
    chk({tag, ".len"}, 32'(out_len), 32'(elen));
  endtask

  initial begin
    reset = 1'b1;
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    reset = 1'b0;
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.in_ready", 32'(in_ready), 1);
    chk("rst.overflow", 32'(overflow), 0);
    chk("rst.out_len", 32'(out_len), 0);
    chk("rst.a0", 32'(a[0]), 0);

    // 1: basic vector with out_ready=1
    step(1, 0, 8'd1, 1);
    chk("t1.early_valid", 32'(out_valid), 0);
    step(1, 0, 8'd2, 1);
    step(1, 0, 8'd3, 1);
    chk_vec("t1", 8'd1, 8'd2, 8'd3, 2'd3);
    step(0, 0, 8'd0, 1);
    chk("t1.one_cycle", 32'(out_valid), 0);

    // 2: both banks full, overflow, drain
    step(1, 0, 8'd1, 0);
    step(1, 0, 8'd2, 0);
    step(1, 0, 8'd3, 0);
    chk("t2.ready_mid", 32'(in_ready), 1);
    step(1, 0, 8'd4, 0);
    step(1, 0, 8'd5, 0);
    step(1, 0, 8'd6, 0);
    chk("t2.ready_full", 32'(in_ready), 0);
    chk_vec("t2.v0_held", 8'd1, 8'd2, 8'd3, 2'd3);
    chk("t2.no_ovf_yet", 32'(overflow), 0);
    step(1, 0, 8'd9, 0);
    chk("t2.overflow", 32'(overflow), 1);
    chk_vec("t2.v0_stable", 8'd1, 8'd2, 8'd3, 2'd3);
    step(0, 0, 8'd0, 1);
    chk_vec("t2.v1", 8'd4, 8'd5, 8'd6, 2'd3);
    chk("t2.ready_back", 32'(in_ready), 1);
    step(0, 0, 8'd0, 1);
    chk("t2.drained", 32'(out_valid), 0);
    chk("t2.ovf_sticky", 32'(overflow), 1);

    // 3: early termination, then a full vector
    step(1, 0, 8'd7, 1);
    step(1, 1, 8'd8, 1);
    chk_vec("t3.short", 8'd7, 8'd8, 8'd0, 2'd2);
    step(1, 0, 8'd1, 1);
    chk("t3.consumed", 32'(out_valid), 0);
    step(1, 0, 8'd2, 1);
    step(1, 0, 8'd3, 1);
    chk_vec("t3.full", 8'd1, 8'd2, 8'd3, 2'd3);
    step(0, 0, 8'd0, 1);
    chk("t3.ovf_still", 32'(overflow), 1);

    // 4: reset mid-fill discards partial data
    step(1, 0, 8'd5, 1);
    step(1, 0, 8'd6, 1);
    reset = 1'b1;
    step(0, 0, 8'd0, 1);
    reset = 1'b0;
    chk("t4.out_valid", 32'(out_valid), 0);
    chk("t4.overflow", 32'(overflow), 0);
    chk("t4.in_ready", 32'(in_ready), 1);
    step(1, 0, 8'd1, 1);
    step(1, 0, 8'd2, 1);
    step(1, 0, 8'd3, 1);
    chk_vec("t4.clean", 8'd1, 8'd2, 8'd3, 2'd3);
    step(0, 0, 8'd0, 1);

    // 5: write completion and read accept in the same cycle
    step(1, 0, 8'd1, 0);
    step(1, 0, 8'd2, 0);
    step(1, 0, 8'd3, 0);
    step(1, 0, 8'd4, 0);
    step(1, 0, 8'd5, 0);
    chk_vec("t5.b0_held", 8'd1, 8'd2, 8'd3, 2'd3);
    step(1, 0, 8'd6, 1);
    chk_vec("t5.b1_next", 8'd4, 8'd5, 8'd6, 2'd3);
    chk("t5.in_ready", 32'(in_ready), 1);
    step(0, 0, 8'd0, 1);
    chk("t5.drained", 32'(out_valid), 0);

    // 6: continuous stream of 12 elements
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 8'(10 + i), 1);
      chk("t6.in_ready", 32'(in_ready), 1);
      if (i % 3 == 2) chk_vec("t6.vec", 8'(8 + i), 8'(9 + i), 8'(10 + i), 2'd3);
      else            chk("t6.gap", 32'(out_valid), 0);
    end
    step(0, 0, 8'd0, 1);
    chk("t6.drained", 32'(out_valid), 0);
    chk("t6.no_ovf", 32'(overflow), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
